bch_dec_serial_t2: RTL and testbench

- Sequential, parametrised double-error-correcting binary BCH decoder over GF(2^M), primitive code length N = 2^M-1.
- Accepts a received codeword bit-serially through a valid/ready handshake and buffers it. Computes S1/S3 by Horner LFSRs, solves the t=2 error locator with an iterative inverse, then runs a Chien search to build an error mask.
- Streams the K corrected message bits out with status flags.
- Multi-cycle successor to the combinational (15,7) decode path; shares its field convention (alpha = x, PRIM_POLY x^4+x+1 at M=4).

---
 rtl/bch_dec_serial_t2.sv | 200 ++++++++++++++++++++
 tb/tb_bch_dec_serial_t2.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_dec_serial_t2.sv
// Bit-serial double-error-correcting binary BCH decoder over GF(2^M).
// The frame is buffered, syndromes are built on the fly, then solve, Chien search, fix and stream.
module bch_dec_serial_t2 #(
    parameter int         M         = 4,
    parameter logic [M:0] PRIM_POLY = 5'b10011,
    parameter int         K         = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    input  logic       i_in_bit,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic       o_out_bit,
    output logic       o_out_last,
    output logic [1:0] o_err_count,
    output logic       o_uncorr,
    output logic       o_busy
);

    localparam int N  = (1 << M) - 1;
    localparam int CW = M + 1;

    // Shift-and-reduce multiply: M partial products, reduction by PRIM_POLY each step.
    function automatic logic [M-1:0] gfMul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] acc;
        logic [M-1:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[M-2:0], 1'b0} ^ (sh[M-1] ? PRIM_POLY[M-1:0] : '0);
        end
        return acc;
    endfunction

    localparam logic [M-1:0] A1 = M'(2);
    localparam logic [M-1:0] A2 = gfMul(A1, A1);
    localparam logic [M-1:0] A3 = gfMul(A2, A1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SOLVE, S_CHIEN, S_FIX, S_OUT} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [N-1:0]    r_buf;
    logic [N-1:0]    r_mask;
    logic [M-1:0]    r_s1;
    logic [M-1:0]    r_s3;
    logic [M-1:0]    r_inv;
    logic [M-1:0]    r_cube;
    logic [M-1:0]    r_r1;
    logic [M-1:0]    r_r2;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_deg;
    logic [1:0]      r_roots;
    logic [1:0]      r_err;
    logic            r_uncorr;

    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_last;
    logic            w_root;
    logic [M-1:0]    w_bit;
    logic [M-1:0]    w_prod;
    logic [M-1:0]    w_sigma2;

    assign w_in_fire  = i_in_valid & o_in_ready;
    assign w_out_fire = o_out_valid & i_out_ready;
    assign w_last     = (r_cnt == CW'(K - 1));
    assign w_bit      = {{(M-1){1'b0}}, i_in_bit};
    assign w_prod     = gfMul(r_inv, r_s1);
    assign w_sigma2   = gfMul(r_s3 ^ r_cube, r_inv);
    assign w_root     = ((r_r1 ^ r_r2 ^ M'(1)) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                o_in_ready = 1'b1;
                o_busy     = 1'b0;
                if (i_in_valid) w_next = S_LOAD;
            end
            S_LOAD: begin
                o_in_ready = 1'b1;
                if (i_in_valid && r_cnt == CW'(N - 1)) w_next = S_SOLVE;
            end
            S_SOLVE: begin
                if (r_cnt == CW'(M)) w_next = (r_s1 == '0) ? S_OUT : S_CHIEN;
            end
            S_CHIEN: begin
                if (r_cnt == '0) w_next = S_FIX;
            end
            S_FIX:   w_next = S_OUT;
            S_OUT: begin
                o_out_valid = 1'b1;
                if (i_out_ready && w_last) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign o_out_bit   = o_out_valid & r_buf[N-1];
    assign o_out_last  = o_out_valid & w_last;
    assign o_err_count = o_out_valid ? r_err : 2'b00;
    assign o_uncorr    = o_out_valid & r_uncorr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf    <= '0;
            r_mask   <= '0;
            r_s1     <= '0;
            r_s3     <= '0;
            r_inv    <= '0;
            r_cube   <= '0;
            r_r1     <= '0;
            r_r2     <= '0;
            r_cnt    <= '0;
            r_deg    <= '0;
            r_roots  <= '0;
            r_err    <= '0;
            r_uncorr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_in_fire) begin
                    r_buf    <= {r_buf[N-2:0], i_in_bit};
                    r_s1     <= w_bit;
                    r_s3     <= w_bit;
                    r_cnt    <= CW'(1);
                    r_mask   <= '0;
                    r_inv    <= M'(1);
                    r_deg    <= '0;
                    r_roots  <= '0;
                    r_err    <= '0;
                    r_uncorr <= 1'b0;
                end
                S_LOAD: if (w_in_fire) begin
                    r_buf <= {r_buf[N-2:0], i_in_bit};
                    r_s1  <= gfMul(r_s1, A1) ^ w_bit;
                    r_s3  <= gfMul(r_s3, A3) ^ w_bit;
                    r_cnt <= (r_cnt == CW'(N - 1)) ? '0 : r_cnt + CW'(1);
                end
                S_SOLVE: begin
                    r_cnt <= r_cnt + CW'(1);
                    // r_inv walks S1^(2^(c+1)-2); after M-1 steps it is S1^-1.
                    if (r_cnt < CW'(M - 1)) begin
                        r_inv <= gfMul(w_prod, w_prod);
                    end else if (r_cnt == CW'(M - 1)) begin
                        r_cube <= gfMul(gfMul(r_s1, r_s1), r_s1);
                    end else if (r_s1 == '0) begin
                        r_cnt    <= '0;
                        r_uncorr <= (r_s3 != '0);
                    end else begin
                        r_cnt <= CW'(N - 1);
                        r_r1  <= gfMul(r_s1, A1);
                        if (r_cube == r_s3) begin
                            r_deg <= 2'd1;
                            r_r2  <= '0;
                        end else begin
                            r_deg <= 2'd2;
                            r_r2  <= gfMul(w_sigma2, A2);
                        end
                    end
                end
                S_CHIEN: begin
                    if (w_root) begin
                        r_mask[r_cnt[M-1:0]] <= 1'b1;
                        if (r_roots != 2'd3) r_roots <= r_roots + 2'd1;
                    end
                    r_r1 <= gfMul(r_r1, A1);
                    r_r2 <= gfMul(r_r2, A2);
                    if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
                end
                S_FIX: begin
                    if (r_roots == r_deg) begin
                        r_buf <= r_buf ^ r_mask;
                        r_err <= r_deg;
                    end else begin
                        r_uncorr <= 1'b1;
                    end
                    r_cnt <= '0;
                end
                S_OUT: if (w_out_fire) begin
                    r_buf <= {r_buf[N-2:0], 1'b0};
                    r_cnt <= r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bch_dec_serial_t2.sv
// Self-checking bench for bch_dec_serial_t2 at M=4, K=7: directed frames plus randomized
// frames scored against a nearest-codeword (distance <= 2) reference model.
module tb_bch_dec_serial_t2;

    localparam int         M    = 4;
    localparam int         N    = 15;
    localparam int         K    = 7;
    localparam logic [M:0] PRIM = 5'b10011;

    logic       clk;
    logic       rst_n;
    logic       inValid;
    logic       inReady;
    logic       inBit;
    logic       outValid;
    logic       outReady;
    logic       outBit;
    logic       outLast;
    logic [1:0] errCount;
    logic       uncorr;
    logic       busy;

    int compared   = 0;
    int mismatched = 0;

    logic [M-1:0] alphaPow [0:N-1];
    logic [N-1:0] codebook [$];

    bch_dec_serial_t2 #(.M(M), .PRIM_POLY(PRIM), .K(K)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_in_valid (inValid),
        .o_in_ready (inReady),
        .i_in_bit   (inBit),
        .o_out_valid(outValid),
        .i_out_ready(outReady),
        .o_out_bit  (outBit),
        .o_out_last (outLast),
        .o_err_count(errCount),
        .o_uncorr   (uncorr),
        .o_busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Syndromes straight from the definition: sum of alpha^i and alpha^(3i) over set bits.
    function automatic logic [M-1:0] synd(input logic [N-1:0] w, input int pw);
        logic [M-1:0] s;
        s = '0;
        for (int i = 0; i < N; i++)
            if (w[i]) s = s ^ alphaPow[(pw * i) % N];
        return s;
    endfunction

    function automatic bit isCodeword(input logic [N-1:0] w);
        return (synd(w, 1) == '0) && (synd(w, 3) == '0);
    endfunction

    // Reference: find the unique codeword within distance 2, else report failure.
    task automatic modelDecode(input logic [N-1:0] rx, output logic [N-1:0] fixedWord,
                               output int errs, output int unc);
        logic [N-1:0] e;
        bit found;
        found = 0; fixedWord = rx; errs = 0; unc = 1;
        if (isCodeword(rx)) begin
            found = 1; unc = 0;
        end
        for (int i = 0; i < N && !found; i++) begin
            e = '0; e[i] = 1'b1;
            if (isCodeword(rx ^ e)) begin
                found = 1; fixedWord = rx ^ e; errs = 1; unc = 0;
            end
        end
        for (int i = 0; i < N && !found; i++)
            for (int j = i + 1; j < N && !found; j++) begin
                e = '0; e[i] = 1'b1; e[j] = 1'b1;
                if (isCodeword(rx ^ e)) begin
                    found = 1; fixedWord = rx ^ e; errs = 2; unc = 0;
                end
            end
    endtask

    task automatic applyStimulus(input logic [N-1:0] frame, input bit gaps);
        bit readyOk;
        int waitCnt;
        readyOk = 1;
        for (int i = N - 1; i >= 0; i--) begin
            if (gaps) begin
                inValid = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                end
            end
            inValid = 1'b1;
            inBit   = frame[i];
            waitCnt = 0;
            while (!inReady && waitCnt < 50) begin
                @(posedge clk); #1;
                waitCnt++;
            end
            if (!inReady) readyOk = 0;
            @(posedge clk); #1;
        end
        inValid = 1'b0;
        inBit   = 1'b0;
        checkOutput("in_ready_during_load", int'(readyOk), 1);
    endtask

    task automatic receiveOutput(input logic [K-1:0] expData, input int expErr, input int expUnc,
                                 input int expLat, input int stallBeat);
        int cyc;
        logic [K-1:0] gotData;
        logic [K-1:0] gotLast;
        int gotErr;
        int gotUnc;
        bit validOk;
        bit stableOk;
        logic holdBit;
        gotData = '0; gotLast = '0; gotErr = 0; gotUnc = 0;
        validOk = 1; stableOk = 1;
        outReady = 1'b0;
        cyc = 0;
        while (!outValid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("latency", cyc, expLat);
        checkOutput("in_ready_while_busy", int'(inReady), 0);
        for (int b = 0; b < K; b++) begin
            if (b == stallBeat) begin
                outReady = 1'b0;
                holdBit  = outBit;
                repeat (20) begin
                    @(posedge clk); #1;
                    if (outBit !== holdBit || !outValid || inReady) stableOk = 0;
                end
                checkOutput("stall_stable", int'(stableOk), 1);
            end
            outReady = 1'b1;
            if (!outValid) validOk = 0;
            gotData = {gotData[K-2:0], outBit};
            gotLast = {gotLast[K-2:0], outLast};
            if (b == 0) begin
                gotErr = int'(errCount);
                gotUnc = int'(uncorr);
            end
            @(posedge clk); #1;
        end
        outReady = 1'b0;
        checkOutput("out_valid_held", int'(validOk), 1);
        checkOutput("data", int'(gotData), int'(expData));
        checkOutput("out_last", int'(gotLast), 1);
        checkOutput("err_count", gotErr, expErr);
        checkOutput("uncorr", gotUnc, expUnc);
        checkOutput("idle_after", int'({busy, outValid, inReady}), 1);
    endtask

    task automatic runModelFrame(input logic [N-1:0] rx, input bit gaps, input int stallBeat);
        logic [N-1:0] fixedWord;
        int errs;
        int unc;
        modelDecode(rx, fixedWord, errs, unc);
        applyStimulus(rx, gaps);
        receiveOutput(fixedWord[N-1:N-K], errs, unc,
                      (synd(rx, 1) == '0) ? M + 1 : M + 1 + N + 1, stallBeat);
    endtask

    typedef struct {
        logic [N-1:0] frame;
        logic [K-1:0] data;
        int           err;
        int           unc;
        int           lat;
    } directed_t;

    directed_t dirList [$];

    initial begin
        logic [M-1:0] p;
        logic [N-1:0] w;
        logic [N-1:0] rx;
        bit quiet;

        rst_n    = 1'b0;
        inValid  = 1'b0;
        inBit    = 1'b0;
        outReady = 1'b0;

        p = M'(1);
        for (int i = 0; i < N; i++) begin
            alphaPow[i] = p;
            p = {p[M-2:0], 1'b0} ^ (p[M-1] ? PRIM[M-1:0] : '0);
        end
        for (int v = 0; v < (1 << N); v++) begin
            w = v[N-1:0];
            if (isCodeword(w)) codebook.push_back(w);
        end
        checkOutput("codebook_size", codebook.size(), 128);

        #12;
        checkOutput("reset_outputs",
                    int'({inReady, outValid, outBit, outLast, errCount, uncorr, busy}), 8'h80);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        dirList.push_back('{15'h0000, 7'h00, 0, 0, M + 1});
        dirList.push_back('{15'h7FFF, 7'h7F, 0, 0, M + 1});
        dirList.push_back('{15'h4000, 7'h00, 1, 0, M + 1 + N + 1});
        dirList.push_back('{15'h7FFE, 7'h7F, 1, 0, M + 1 + N + 1});
        dirList.push_back('{15'h0408, 7'h00, 2, 0, M + 1 + N + 1});
        dirList.push_back('{15'h4100, 7'h00, 2, 0, M + 1 + N + 1});
        dirList.push_back('{15'h0013, 7'h00, 0, 1, M + 1});
        foreach (dirList[d]) begin
            applyStimulus(dirList[d].frame, 1'b0);
            receiveOutput(dirList[d].data, dirList[d].err, dirList[d].unc, dirList[d].lat, -1);
        end

        // Input gaps plus a 20-cycle output stall mid-stream.
        rx = codebook[$urandom_range(0, codebook.size() - 1)];
        rx[$urandom_range(0, N - 1)] ^= 1'b1;
        runModelFrame(rx, 1'b1, 3);

        for (int t = 0; t < 30; t++) begin
            if (t % 5 == 4) begin
                rx = N'($urandom);
            end else begin
                rx = codebook[$urandom_range(0, codebook.size() - 1)];
                repeat ($urandom_range(0, 3)) rx[$urandom_range(0, N - 1)] ^= 1'b1;
            end
            runModelFrame(rx, 1'($urandom_range(0, 1)), (t % 3 == 0) ? int'($urandom_range(0, K - 1)) : -1);
        end

        // Reset pulse while the Chien search is running.
        applyStimulus(15'h0220, 1'b0);
        repeat (M + 1 + 4) begin
            @(posedge clk); #1;
        end
        checkOutput("busy_before_reset", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_chien",
                    int'({inReady, outValid, outBit, outLast, errCount, uncorr, busy}), 8'h80);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1;
        repeat (30) begin
            @(posedge clk); #1;
            if (outValid || busy) quiet = 0;
        end
        checkOutput("no_output_after_reset", int'(quiet), 1);
        rx = codebook[$urandom_range(0, codebook.size() - 1)];
        rx[2] ^= 1'b1;
        rx[11] ^= 1'b1;
        runModelFrame(rx, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
